ultrasonic_scheduler: RTL and testbench

ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

---
 rtl/ultrasonic_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_scheduler.sv
// Time-multiplexes one ultrasonic measurement engine across N_SENSORS sensors, one frame per period.
// Optional nearest-object tracking is enabled by defining ULTRASONIC_NEAREST_EN.
module ultrasonic_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int DIST_W         = 8,
  parameter int PERIOD_CYCLES  = 25_000_000,
  parameter int GUARD_CYCLES   = 3_000_000,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [N_SENSORS-1:0]          sensor_mask,
  output logic                          meas_start,
  output logic [$clog2(N_SENSORS)-1:0]  sensor_sel,
  input  logic                          meas_done,
  input  logic [DIST_W-1:0]             meas_distance,
  output logic [N_SENSORS*DIST_W-1:0]   dist_flat,
  output logic [N_SENSORS-1:0]          valid,
  output logic [N_SENSORS-1:0]          timeout_flag,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun
`ifdef ULTRASONIC_NEAREST_EN
  ,
  output logic [DIST_W-1:0]             nearest_dist,
  output logic [$clog2(N_SENSORS)-1:0]  nearest_idx
`endif
);

  localparam int SEL_W    = $clog2(N_SENSORS);
  localparam int PER_W    = $clog2(PERIOD_CYCLES);
  localparam int WAIT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, MEASURE, GUARD} state_t;

  state_t                state, next_state;
  logic [PER_W-1:0]      period_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [N_SENSORS-1:0]  frame_mask;
  logic                  tick;
  logic                  store_done, store_timeout;
  logic [SEL_W-1:0]      first_idx, next_idx;
  logic                  has_next;

  assign tick    = enable && (period_cnt == PER_W'(PERIOD_CYCLES - 1));
  assign busy    = (state != IDLE);
  assign overrun = tick && busy;

  // Lowest set bit of the live mask, and next set bit of the frame mask above the current sensor
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (sensor_mask[i]) first_idx = SEL_W'(i);
      if (frame_mask[i] && (SEL_W'(i) > sensor_sel)) begin
        next_idx = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    next_state    = state;
    meas_start    = 1'b0;
    frame_done    = 1'b0;
    store_done    = 1'b0;
    store_timeout = 1'b0;
    case (state)
      IDLE:    if (tick && (|sensor_mask)) next_state = START;
      START: begin
        meas_start = 1'b1;
        next_state = MEASURE;
      end
      MEASURE: begin
        if (meas_done) begin
          store_done = 1'b1;
          next_state = GUARD;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          store_timeout = 1'b1;
          next_state    = GUARD;
        end
      end
      GUARD: begin
        if (wait_cnt == WAIT_W'(GUARD_CYCLES - 1)) begin
          if (enable && has_next) begin
            next_state = START;
          end else begin
            frame_done = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // wait_cnt restarts from 0 on every state change and serves as both timeout and guard timer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      period_cnt   <= '0;
      wait_cnt     <= '0;
      sensor_sel   <= '0;
      frame_mask   <= '0;
      dist_flat    <= '0;
      valid        <= '0;
      timeout_flag <= '0;
    end else begin
      state <= next_state;
      if (!enable || tick) period_cnt <= '0;
      else                 period_cnt <= period_cnt + 1'b1;
      if ((next_state != state) || (state == IDLE)) wait_cnt <= '0;
      else                                          wait_cnt <= wait_cnt + 1'b1;
      if ((state == IDLE) && (next_state == START)) begin
        frame_mask <= sensor_mask;
        sensor_sel <= first_idx;
      end
      if ((state == GUARD) && (next_state == START)) sensor_sel <= next_idx;
      if (store_done) begin
        dist_flat[sensor_sel*DIST_W +: DIST_W] <= meas_distance;
        valid[sensor_sel]        <= 1'b1;
        timeout_flag[sensor_sel] <= 1'b0;
      end else if (store_timeout) begin
        dist_flat[sensor_sel*DIST_W +: DIST_W] <= '1;
        valid[sensor_sel]        <= 1'b0;
        timeout_flag[sensor_sel] <= 1'b1;
      end
    end
  end

`ifdef ULTRASONIC_NEAREST_EN
  logic [DIST_W-1:0] min_dist;
  logic [SEL_W-1:0]  min_idx;
  logic              min_found;

  // Strict less-than keeps the lowest index on ties
  always_comb begin
    min_dist  = '1;
    min_idx   = '0;
    min_found = 1'b0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (valid[i] && (!min_found || (dist_flat[i*DIST_W +: DIST_W] < min_dist))) begin
        min_dist  = dist_flat[i*DIST_W +: DIST_W];
        min_idx   = SEL_W'(i);
        min_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nearest_dist <= '1;
      nearest_idx  <= '0;
    end else if (frame_done) begin
      nearest_dist <= min_dist;
      nearest_idx  <= min_idx;
    end
  end
`endif

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with a small engine responder and event monitor.
// Define ULTRASONIC_NEAREST_EN for both files to exercise the nearest-object outputs.
module tb_ultrasonic_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n, enable, meas_done;
  logic [N-1:0]    sensor_mask;
  logic [DW-1:0]   meas_distance;
  logic            meas_start, busy, frame_done, overrun;
  logic [1:0]      sensor_sel;
  logic [N*DW-1:0] dist_flat;
  logic [N-1:0]    valid, timeout_flag;
`ifdef ULTRASONIC_NEAREST_EN
  logic [DW-1:0]   nearest_dist;
  logic [1:0]      nearest_idx;
`endif

  ultrasonic_scheduler #(
    .N_SENSORS(N), .DIST_W(DW), .PERIOD_CYCLES(100), .GUARD_CYCLES(10), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_mask(sensor_mask),
    .meas_start(meas_start), .sensor_sel(sensor_sel), .meas_done(meas_done),
    .meas_distance(meas_distance), .dist_flat(dist_flat), .valid(valid),
    .timeout_flag(timeout_flag), .busy(busy), .frame_done(frame_done), .overrun(overrun)
`ifdef ULTRASONIC_NEAREST_EN
    , .nearest_dist(nearest_dist), .nearest_idx(nearest_idx)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, start_cnt = 0, fd_cnt = 0, ovr_cnt = 0;
  int last_start_cyc = 0, to0_rise_cyc = 0;
  logic [1:0] start_log [64];
  logic       prev_to0 = 1'b0;
  logic       eng_on = 1'b1;
  int         eng_delay = 5;
  logic [DW-1:0] eng_dist [N];

  // Event monitor sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (meas_start === 1'b1) begin
      start_log[start_cnt % 64] = sensor_sel;
      start_cnt++;
      last_start_cyc = cyc;
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if ((timeout_flag[0] === 1'b1) && (prev_to0 === 1'b0)) to0_rise_cyc = cyc;
    prev_to0 = timeout_flag[0];
  end

  // Engine model: answers eng_delay cycles after meas_start with the distance for the selected sensor
  initial begin
    logic [1:0] sel;
    meas_done     = 1'b0;
    meas_distance = '0;
    forever begin
      @(negedge clk);
      if ((meas_start === 1'b1) && eng_on) begin
        sel = sensor_sel;
        repeat (eng_delay) @(negedge clk);
        meas_distance = eng_dist[sel];
        meas_done     = 1'b1;
        @(negedge clk);
        meas_done     = 1'b0;
        meas_distance = '0;
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [N-1:0] mask);
    enable      = en;
    sensor_mask = mask;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fd(input string tag, input int budget);
    int base = fd_cnt;
    int n = 0;
    while ((fd_cnt == base) && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    assert (fd_cnt != base) else begin
      errors++;
      $error("[TB] FAIL %s frame_done observed=none expected=pulse within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_start(input string tag, input int budget);
    int base = start_cnt;
    int n = 0;
    while ((start_cnt == base) && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    assert (start_cnt != base) else begin
      errors++;
      $error("[TB] FAIL %s meas_start observed=none expected=pulse within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    int n, base_s, base_f, base_o;
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0000);
    eng_dist[0] = 8'd20; eng_dist[1] = 8'd30; eng_dist[2] = 8'hAA; eng_dist[3] = 8'd40;
    tick_n(5);

    checkOutput("rst_dist", 64'(dist_flat), 64'h0);
    checkOutput("rst_valid", 64'(valid), 64'h0);
    checkOutput("rst_timeout", 64'(timeout_flag), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_start", 64'(meas_start), 64'h0);
    checkOutput("rst_sel", 64'(sensor_sel), 64'h0);
`ifdef ULTRASONIC_NEAREST_EN
    checkOutput("rst_nearest_dist", 64'(nearest_dist), 64'hFF);
    checkOutput("rst_nearest_idx", 64'(nearest_idx), 64'h0);
`endif

    // First frame: tick 100 cycles after release, mask 1011, mask changed mid-frame
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b1011);
    n = 0;
    while (!busy && (n < 200)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("first_tick_latency", 64'(n), 64'd100);
    base_s = start_cnt;
    base_f = fd_cnt;
    sensor_mask = 4'b0100;
    wait_fd("frame_1011", 300);
    enable = 1'b0;
    checkOutput("f1_starts", 64'(start_cnt - base_s), 64'd3);
    checkOutput("f1_sel0", 64'(start_log[base_s % 64]), 64'd0);
    checkOutput("f1_sel1", 64'(start_log[(base_s + 1) % 64]), 64'd1);
    checkOutput("f1_sel2", 64'(start_log[(base_s + 2) % 64]), 64'd3);
    checkOutput("f1_dist", 64'(dist_flat), 64'h28001E14);
    checkOutput("f1_valid", 64'(valid), 64'b1011);
    checkOutput("f1_fd_count", 64'(fd_cnt - base_f), 64'd1);
    tick_n(2);
    checkOutput("f1_idle", 64'(busy), 64'h0);

    // Timeout on sensor 0, then a retry that answers 7
    eng_on = 1'b0;
    applyStimulus(1'b1, 4'b0001);
    wait_fd("timeout_frame", 300);
    eng_on = 1'b1;
    eng_dist[0] = 8'd7;
    checkOutput("to_dist", 64'(dist_flat), 64'h28001EFF);
    checkOutput("to_valid", 64'(valid), 64'b1010);
    checkOutput("to_flag", 64'(timeout_flag), 64'b0001);
    // MEASURE spans the 50 cycles after meas_start; the flag is seen on the following falling edge
    checkOutput("to_latency", 64'(to0_rise_cyc - last_start_cyc), 64'd51);
    wait_fd("retry_frame", 200);
    enable = 1'b0;
    checkOutput("retry_dist", 64'(dist_flat), 64'h28001E07);
    checkOutput("retry_valid", 64'(valid), 64'b1011);
    checkOutput("retry_flag", 64'(timeout_flag), 64'b0000);

    // meas_done on the exact timeout cycle must win
    eng_delay = 50;
    eng_dist[0] = 8'd9;
    applyStimulus(1'b1, 4'b0001);
    wait_fd("coincident_frame", 300);
    enable = 1'b0;
    checkOutput("coin_dist", 64'(dist_flat), 64'h28001E09);
    checkOutput("coin_valid", 64'(valid), 64'b1011);
    checkOutput("coin_flag", 64'(timeout_flag), 64'b0000);

    // Long frame: 4 sensors x 56 cycles = 224 cycles, so the ticks at +100 and +200 both land while busy
    eng_delay = 45;
    eng_dist[0] = 8'h11; eng_dist[1] = 8'h22; eng_dist[2] = 8'h33; eng_dist[3] = 8'h44;
    base_s = start_cnt;
    base_o = ovr_cnt;
    base_f = fd_cnt;
    applyStimulus(1'b1, 4'b1111);
    wait_fd("long_frame", 600);
    enable = 1'b0;
    checkOutput("long_starts", 64'(start_cnt - base_s), 64'd4);
    checkOutput("long_last_sel", 64'(start_log[(base_s + 3) % 64]), 64'd3);
    checkOutput("long_overrun_cycles", 64'(ovr_cnt - base_o), 64'd2);
    checkOutput("long_fd_count", 64'(fd_cnt - base_f), 64'd1);
    checkOutput("long_dist", 64'(dist_flat), 64'h44332211);
    checkOutput("long_valid", 64'(valid), 64'b1111);

    // enable dropped during the first measurement ends the frame after its guard
    eng_delay = 5;
    eng_dist[0] = 8'h55;
    base_s = start_cnt;
    applyStimulus(1'b1, 4'b1111);
    wait_start("stop_start", 200);
    enable = 1'b0;
    wait_fd("stop_frame", 100);
    checkOutput("stop_starts", 64'(start_cnt - base_s), 64'd1);
    checkOutput("stop_dist", 64'(dist_flat), 64'h44332255);
    tick_n(1);
    checkOutput("stop_idle", 64'(busy), 64'h0);

`ifdef ULTRASONIC_NEAREST_EN
    eng_dist[0] = 8'd50; eng_dist[1] = 8'd12; eng_dist[2] = 8'd12; eng_dist[3] = 8'd80;
    applyStimulus(1'b1, 4'b1111);
    wait_fd("nearest_frame", 400);
    enable = 1'b0;
    checkOutput("nearest_dist", 64'(nearest_dist), 64'd12);
    checkOutput("nearest_idx", 64'(nearest_idx), 64'd1);
`endif

    // One-cycle reset in MEASURE; the engine's late answer must be ignored
    eng_delay = 20;
    eng_dist[0] = 8'h66;
    applyStimulus(1'b1, 4'b0001);
    wait_start("rst_frame_start", 200);
    base_f = fd_cnt;
    tick_n(3);
    rst_n = 1'b0;
    enable = 1'b0;
    tick_n(1);
    rst_n = 1'b1;
    checkOutput("mrst_dist", 64'(dist_flat), 64'h0);
    checkOutput("mrst_valid", 64'(valid), 64'h0);
    checkOutput("mrst_timeout", 64'(timeout_flag), 64'h0);
    checkOutput("mrst_busy", 64'(busy), 64'h0);
    checkOutput("mrst_start", 64'(meas_start), 64'h0);
    checkOutput("mrst_sel", 64'(sensor_sel), 64'h0);
    checkOutput("mrst_fd", 64'(frame_done), 64'h0);
    checkOutput("mrst_overrun", 64'(overrun), 64'h0);
    tick_n(30);
    checkOutput("late_done_dist", 64'(dist_flat), 64'h0);
    checkOutput("late_done_valid", 64'(valid), 64'h0);
    checkOutput("late_done_fd", 64'(fd_cnt - base_f), 64'd0);

    // Ticks with an empty mask start nothing
    base_s = start_cnt;
    base_f = fd_cnt;
    base_o = ovr_cnt;
    applyStimulus(1'b1, 4'b0000);
    tick_n(150);
    checkOutput("empty_starts", 64'(start_cnt - base_s), 64'd0);
    checkOutput("empty_fd", 64'(fd_cnt - base_f), 64'd0);
    checkOutput("empty_overrun", 64'(ovr_cnt - base_o), 64'd0);
    checkOutput("empty_busy", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
